// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between instruction fetch (F) and load/store (D).
// D has priority; a streak counter forces an F grant after MAX_STREAK D grants while F waits.
module mem_port_arbiter #(
  parameter int AW         = 20,
  parameter int DW         = 20,
  parameter int MEM_LAT    = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_write,
  output logic          mem_load,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(MAX_STREAK + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_MEM, DONE} state_t;

  state_t        state;
  logic          owner_f;
  logic          we;
  logic [CW-1:0] lat_cnt;
  logic [SW-1:0] streak;
  logic          f_wins;

  // F only beats a pending D once D has won MAX_STREAK times in a row over it.
  assign f_wins = f_req && (!d_req || (streak == SW'(MAX_STREAK)));
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner_f   <= 1'b0;
      we        <= 1'b0;
      lat_cnt   <= '0;
      streak    <= '0;
      f_ack     <= 1'b0;
      d_ack     <= 1'b0;
      f_rdata   <= '0;
      d_rdata   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
      mem_load  <= 1'b0;
    end else begin
      mem_write <= 1'b0;
      mem_load  <= 1'b0;
      f_ack     <= 1'b0;
      d_ack     <= 1'b0;
      case (state)
        IDLE: begin
          if (f_req || d_req) begin
            owner_f <= f_wins;
            state   <= ISSUE;
            if (f_wins) begin
              we        <= 1'b0;
              mem_addr  <= f_addr;
              mem_wdata <= '0;
              mem_load  <= 1'b1;
              streak    <= '0;
            end else begin
              we        <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_write <= d_we;
              mem_load  <= !d_we;
              if (!f_req)
                streak <= '0;
              else if (streak != SW'(MAX_STREAK))
                streak <= streak + SW'(1);
            end
          end
        end
        ISSUE: begin
          // Stores complete without a read wait; only D can own a store.
          if (we) begin
            d_ack <= 1'b1;
            state <= DONE;
          end else begin
            lat_cnt <= CW'(MEM_LAT);
            state   <= WAIT_MEM;
          end
        end
        WAIT_MEM: begin
          lat_cnt <= lat_cnt - CW'(1);
          if (lat_cnt == CW'(1)) begin
            state <= DONE;
            if (owner_f) begin
              f_rdata <= mem_rdata;
              f_ack   <= 1'b1;
            end else begin
              d_rdata <= mem_rdata;
              d_ack   <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3,
// each with a small RAM model whose read data appears exactly MEM_LAT cycles after mem_load.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        f_req = 1'b0;
  logic [19:0] f_addr = '0;
  logic        f_ack;
  logic [19:0] f_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [19:0] d_addr = '0;
  logic [19:0] d_wdata = '0;
  logic        d_ack;
  logic [19:0] d_rdata;
  logic [19:0] mem_addr;
  logic [19:0] mem_wdata;
  logic        mem_write;
  logic        mem_load;
  logic [19:0] mem_rdata;
  logic        busy;

  logic        f3_req = 1'b0;
  logic [19:0] f3_addr = '0;
  logic        f3_ack;
  logic [19:0] f3_rdata;
  logic        d3_req = 1'b0;
  logic        d3_we = 1'b0;
  logic [19:0] d3_addr = '0;
  logic [19:0] d3_wdata = '0;
  logic        d3_ack;
  logic [19:0] d3_rdata;
  logic [19:0] mem3_addr;
  logic [19:0] mem3_wdata;
  logic        mem3_write;
  logic        mem3_load;
  logic [19:0] mem3_rdata;
  logic        busy3;

  int compared   = 0;
  int mismatched = 0;
  int dual_acks  = 0;
  int strobe_clash = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(20), .DW(20), .MEM_LAT(1), .MAX_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_load(mem_load), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.AW(20), .DW(20), .MEM_LAT(3), .MAX_STREAK(4)) dut3 (
    .clk(clk), .rst(rst),
    .f_req(f3_req), .f_addr(f3_addr), .f_ack(f3_ack), .f_rdata(f3_rdata),
    .d_req(d3_req), .d_we(d3_we), .d_addr(d3_addr), .d_wdata(d3_wdata),
    .d_ack(d3_ack), .d_rdata(d3_rdata),
    .mem_addr(mem3_addr), .mem_wdata(mem3_wdata), .mem_write(mem3_write),
    .mem_load(mem3_load), .mem_rdata(mem3_rdata), .busy(busy3)
  );

  // RAM models: preloaded on the first clock edge, reads return 0 unless a load was issued.
  logic [19:0] ram1 [0:255];
  logic [19:0] ram3 [0:255];
  logic        ram_init = 1'b0;
  logic [19:0] p1 = '0;
  logic [19:0] p3a = '0, p3b = '0, p3c = '0;

  always @(posedge clk) begin
    if (!ram_init) begin
      ram1[8'h10] <= 20'hABCDE;
      ram3[8'h40] <= 20'h5A5A5;
      ram_init    <= 1'b1;
    end else begin
      if (mem_write)  ram1[mem_addr[7:0]]  <= mem_wdata;
      if (mem3_write) ram3[mem3_addr[7:0]] <= mem3_wdata;
    end
    p1  <= mem_load  ? ram1[mem_addr[7:0]]  : 20'h0;
    p3a <= mem3_load ? ram3[mem3_addr[7:0]] : 20'h0;
    p3b <= p3a;
    p3c <= p3b;
  end

  assign mem_rdata  = p1;
  assign mem3_rdata = p3c;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advances on negedges until dut raises an ack or the budget runs out.
  task automatic waitAck(input int budget, output int cycles, output logic got_f, output logic got_d);
    cycles = 0;
    got_f  = 1'b0;
    got_d  = 1'b0;
    while (cycles < budget && !got_f && !got_d) begin
      @(negedge clk);
      cycles++;
      got_f = f_ack;
      got_d = d_ack;
      if (f_ack && d_ack) dual_acks++;
      if (mem_write && mem_load) strobe_clash++;
    end
  endtask

  task automatic applyStimulus(input logic fr, input logic [19:0] fa,
                               input logic dr, input logic dw, input logic [19:0] da,
                               input logic [19:0] dd);
    f_req   = fr;
    f_addr  = fa;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dd;
  endtask

  initial begin
    int   n;
    logic gf, gd;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_acks", {f_ack, d_ack}, 0);
    checkOutput("rst_strobes", {mem_write, mem_load}, 0);
    checkOutput("rst_f_rdata", f_rdata, 0);
    checkOutput("rst_d_rdata", d_rdata, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single fetch
    applyStimulus(1, 20'h00010, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t1_c1_mem_load", mem_load, 1);
    checkOutput("t1_c1_mem_addr", mem_addr, 20'h00010);
    checkOutput("t1_c1_busy", busy, 1);
    @(negedge clk);
    checkOutput("t1_c2_mem_load", mem_load, 0);
    checkOutput("t1_c2_f_ack", f_ack, 0);
    @(negedge clk);
    checkOutput("t1_c3_f_ack", f_ack, 1);
    checkOutput("t1_c3_f_rdata", f_rdata, 20'hABCDE);
    checkOutput("t1_c3_d_ack", d_ack, 0);
    f_req = 1'b0;
    @(negedge clk);
    checkOutput("t1_c4_busy", busy, 0);
    checkOutput("t1_c4_f_ack", f_ack, 0);
    checkOutput("t1_c4_f_rdata_held", f_rdata, 20'hABCDE);

    // 2: store then load back
    applyStimulus(0, 0, 1, 1, 20'h00020, 20'h12345);
    @(negedge clk);
    checkOutput("t2_c1_mem_write", mem_write, 1);
    checkOutput("t2_c1_mem_load", mem_load, 0);
    checkOutput("t2_c1_mem_wdata", mem_wdata, 20'h12345);
    checkOutput("t2_c1_mem_addr", mem_addr, 20'h00020);
    @(negedge clk);
    checkOutput("t2_c2_d_ack", d_ack, 1);
    checkOutput("t2_c2_mem_write", mem_write, 0);
    d_req = 1'b0;
    @(negedge clk);
    applyStimulus(0, 0, 1, 0, 20'h00020, 0);
    waitAck(10, n, gf, gd);
    checkOutput("t2_load_latency", n, 3);
    checkOutput("t2_load_owner", {gf, gd}, 2'b01);
    checkOutput("t2_d_rdata", d_rdata, 20'h12345);
    checkOutput("t2_f_rdata_untouched", f_rdata, 20'hABCDE);
    d_req = 1'b0;
    @(negedge clk);

    // 3: simultaneous requests, D first
    applyStimulus(1, 20'h00010, 1, 0, 20'h00020, 0);
    waitAck(10, n, gf, gd);
    checkOutput("t3_first_owner", {gf, gd}, 2'b01);
    checkOutput("t3_first_latency", n, 3);
    checkOutput("t3_d_rdata", d_rdata, 20'h12345);
    d_req = 1'b0;
    waitAck(10, n, gf, gd);
    checkOutput("t3_second_owner", {gf, gd}, 2'b10);
    checkOutput("t3_second_latency", n, 4);
    checkOutput("t3_f_rdata", f_rdata, 20'hABCDE);
    f_req = 1'b0;
    @(negedge clk);

    // 4: back-to-back D stores with F waiting; F forced after 4 D grants
    applyStimulus(1, 20'h00010, 1, 1, 20'h00030, 20'h0BEEF);
    for (int g = 0; g < 4; g++) begin
      waitAck(10, n, gf, gd);
      checkOutput($sformatf("t4_dgrant%0d_owner", g), {gf, gd}, 2'b01);
      checkOutput($sformatf("t4_dgrant%0d_spacing", g), n, (g == 0) ? 2 : 3);
    end
    waitAck(10, n, gf, gd);
    checkOutput("t4_forced_f_owner", {gf, gd}, 2'b10);
    checkOutput("t4_forced_f_spacing", n, 4);
    checkOutput("t4_forced_f_rdata", f_rdata, 20'hABCDE);
    waitAck(10, n, gf, gd);
    checkOutput("t4_streak_cleared_d_wins", {gf, gd}, 2'b01);
    checkOutput("t4_streak_cleared_spacing", n, 3);
    d_req = 1'b0;
    waitAck(10, n, gf, gd);
    checkOutput("t4_final_f_owner", {gf, gd}, 2'b10);
    checkOutput("t4_final_f_spacing", n, 4);
    f_req = 1'b0;
    @(negedge clk);

    // 5: MEM_LAT=3 load on the second instance
    d3_addr = 20'h00040;
    d3_we   = 1'b0;
    d3_req  = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checkOutput($sformatf("t5_c%0d_mem_load", k), mem3_load, (k == 1));
      checkOutput($sformatf("t5_c%0d_d_ack", k), d3_ack, (k == 5));
      checkOutput($sformatf("t5_c%0d_f_ack", k), f3_ack, 0);
      if (k == 1) checkOutput("t5_c1_mem_addr", mem3_addr, 20'h00040);
      if (k == 5) begin
        checkOutput("t5_d_rdata", d3_rdata, 20'h5A5A5);
        d3_req = 1'b0;
      end
    end
    checkOutput("t5_busy_after", busy3, 0);
    checkOutput("t5_f_rdata_untouched", f3_rdata, 0);

    // 6: reset during WAIT aborts the fetch; then a fresh fetch completes
    applyStimulus(1, 20'h00010, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t6_c1_mem_load", mem_load, 1);
    @(negedge clk);
    checkOutput("t6_c2_busy_before_rst", busy, 1);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_f_rdata", f_rdata, 0);
    checkOutput("t6_rst_d_rdata", d_rdata, 0);
    checkOutput("t6_rst_mem_addr", mem_addr, 0);
    checkOutput("t6_rst_acks", {f_ack, d_ack}, 0);
    f_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t6_no_late_ack", {f_ack, d_ack}, 0);
    applyStimulus(1, 20'h00010, 0, 0, 0, 0);
    waitAck(10, n, gf, gd);
    checkOutput("t6_fresh_owner", {gf, gd}, 2'b10);
    checkOutput("t6_fresh_latency", n, 3);
    checkOutput("t6_fresh_f_rdata", f_rdata, 20'hABCDE);
    f_req = 1'b0;
    @(negedge clk);

    // Reset during a store ISSUE drops mem_write at once
    applyStimulus(0, 0, 1, 1, 20'h00050, 20'h00777);
    @(negedge clk);
    checkOutput("t6_store_mem_write", mem_write, 1);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_mem_write", mem_write, 0);
    checkOutput("t6_rst_mem_wdata", mem_wdata, 0);
    d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t6_store_no_ack", {f_ack, d_ack}, 0);
    checkOutput("t6_store_idle", busy, 0);

    checkOutput("ack_mutual_exclusion", dual_acks, 0);
    checkOutput("strobe_mutual_exclusion", strobe_clash, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
